// File: rtl/muldiv_sequencer_if.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer_if
// Request/response bundle between the EX stage and the multi-cycle RV32M unit.
//   start_i   : request a new operation (pipeline -> unit)
//   funct3_i  : M-extension operation select
//   rs1_i     : multiplicand / dividend
//   rs2_i     : multiplier / divisor
//   flush_i   : abort the in-flight operation
//   busy_o    : operation in progress, EX must hold (unit -> pipeline)
//   done_o    : one-cycle pulse, result_o valid
//   result_o  : result, held until the next done_o
// master = pipeline side, slave = muldiv_sequencer.
// -----------------------------------------------------------------------------
interface muldiv_sequencer_if #(
   parameter int XLEN = 32
);
   logic            start_i;
   logic [2:0]      funct3_i;
   logic [XLEN-1:0] rs1_i;
   logic [XLEN-1:0] rs2_i;
   logic            flush_i;
   logic            busy_o;
   logic            done_o;
   logic [XLEN-1:0] result_o;

   modport master (
      output start_i, funct3_i, rs1_i, rs2_i, flush_i,
      input  busy_o, done_o, result_o
   );

   modport slave (
      input  start_i, funct3_i, rs1_i, rs2_i, flush_i,
      output busy_o, done_o, result_o
   );
endinterface

// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
// Multi-cycle RV32M multiply/divide unit. One shared 2*XLEN accumulator runs
// either XLEN shift-add steps (MUL*) or XLEN restoring-divide steps (DIV*/REM*)
// on operand magnitudes; a FIX cycle then applies signs and picks the result.
// Divide-by-zero and signed overflow finish straight from the start edge.
// Ports:
//   clk_i   : clock, rising edge
//   rst_n_i : asynchronous active-low reset
//   bus     : muldiv_sequencer_if.slave (start/funct3/rs1/rs2/flush in,
//             busy/done/result out; all outputs registered)
// -----------------------------------------------------------------------------
module muldiv_sequencer #(
   parameter int XLEN = 32
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   muldiv_sequencer_if.slave  bus
);

   localparam int CNT_W = $clog2(XLEN);
   localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t            state_q;
   logic [2:0]        funct3_q;
   logic              neg_a_q;
   logic              neg_b_q;
   logic [XLEN-1:0]   mag_a_q;
   logic [XLEN-1:0]   mag_b_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [2*XLEN-1:0] acc_q;
   logic              busy_q;
   logic              done_q;
   logic [XLEN-1:0]   result_q;

   // ---------------- start-time decode ----------------
   logic              signed_a, signed_b;
   logic              neg_a, neg_b;
   logic [XLEN-1:0]   abs_a, abs_b;
   logic              is_div, div_zero, div_ovf, special;
   logic [XLEN-1:0]   special_result;
   logic              accept;

   // NOTE: every signal assigned in always_comb gets a default first, so no
   // path through the block can leave it unassigned and infer a latch.
   always_comb begin
      signed_a       = 1'b0;
      signed_b       = 1'b0;
      special_result = '0;
      case (bus.funct3_i)
         3'b001, 3'b100, 3'b110: begin signed_a = 1'b1; signed_b = 1'b1; end
         3'b010:                 signed_a = 1'b1;
         default:                ;
      endcase
      neg_a    = signed_a & bus.rs1_i[XLEN-1];
      neg_b    = signed_b & bus.rs2_i[XLEN-1];
      abs_a    = neg_a ? -bus.rs1_i : bus.rs1_i;
      abs_b    = neg_b ? -bus.rs2_i : bus.rs2_i;
      is_div   = bus.funct3_i[2];
      div_zero = is_div && (bus.rs2_i == '0);
      div_ovf  = is_div && !bus.funct3_i[0] && (bus.rs1_i == INT_MIN) && (bus.rs2_i == '1);
      special  = div_zero | div_ovf;
      // funct3[1] selects remainder vs quotient among the divide ops.
      if (bus.funct3_i[1])
         special_result = div_zero ? bus.rs1_i : '0;
      else
         special_result = div_zero ? '1 : INT_MIN;
      // A flush in IDLE/DONE only swallows a same-cycle start.
      accept = bus.start_i && !bus.flush_i && (state_q == IDLE || state_q == DONE);
   end

   // ---------------- one iteration of the shared datapath ----------------
   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     rem_shift;
   logic [XLEN:0]     diff;
   logic [2*XLEN-1:0] iter_next;

   always_comb begin
      // Shift-add: acc = {partial_hi, remaining multiplier bits}.
      mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mag_a_q} : '0);
      // Restoring divide: acc = {partial remainder, dividend/quotient bits}.
      // diff[XLEN] is the borrow: the trial subtract did not fit.
      rem_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
      diff      = rem_shift - {1'b0, mag_b_q};
      if (funct3_q[2]) begin
         if (diff[XLEN])
            iter_next = {rem_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
         else
            iter_next = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      end else begin
         iter_next = {mul_sum, acc_q[XLEN-1:1]};
      end
   end

   // ---------------- sign fix-up and result select ----------------
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quo, rem, fix_result;

   always_comb begin
      prod = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
      quo  = (neg_a_q ^ neg_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
      rem  = neg_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
      if (funct3_q[2])
         fix_result = funct3_q[1] ? rem : quo;
      else if (funct3_q[1:0] == 2'b00)
         fix_result = prod[XLEN-1:0];
      else
         fix_result = prod[2*XLEN-1:XLEN];
   end

   // ---------------- sequencer ----------------
   // NOTE: state is updated only with non-blocking assignments so every
   // register samples pre-edge values, independent of statement order.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q  <= IDLE;
         funct3_q <= '0;
         neg_a_q  <= 1'b0;
         neg_b_q  <= 1'b0;
         mag_a_q  <= '0;
         mag_b_q  <= '0;
         cnt_q    <= '0;
         acc_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE, DONE: begin
               busy_q <= 1'b0;
               if (accept) begin
                  funct3_q <= bus.funct3_i;
                  neg_a_q  <= neg_a;
                  neg_b_q  <= neg_b;
                  mag_a_q  <= abs_a;
                  mag_b_q  <= abs_b;
                  cnt_q    <= '0;
                  if (special) begin
                     result_q <= special_result;
                     done_q   <= 1'b1;
                     state_q  <= DONE;
                  end else begin
                     acc_q   <= is_div ? {{XLEN{1'b0}}, abs_a} : {{XLEN{1'b0}}, abs_b};
                     busy_q  <= 1'b1;
                     state_q <= CALC;
                  end
               end else begin
                  state_q <= IDLE;
               end
            end
            CALC: begin
               if (bus.flush_i) begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  acc_q <= iter_next;
                  if (cnt_q == CNT_W'(XLEN-1))
                     state_q <= FIX;
                  else
                     cnt_q <= cnt_q + 1'b1;
               end
            end
            FIX: begin
               busy_q <= 1'b0;
               if (bus.flush_i) begin
                  state_q <= IDLE;
               end else begin
                  result_q <= fix_result;
                  done_q   <= 1'b1;
                  state_q  <= DONE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.busy_o   = busy_q;
   assign bus.done_o   = done_q;
   assign bus.result_o = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// tb_muldiv_sequencer
// Self-checking bench for muldiv_sequencer: directed cases, special cases,
// randomized operations against a 64-bit arithmetic reference model, flush,
// back-to-back issue and mid-operation reset.
// -----------------------------------------------------------------------------
module tb_muldiv_sequencer;

   localparam int XLEN = 32;
   localparam logic [31:0] INT_MIN = 32'h8000_0000;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;
   int   cyc;

   muldiv_sequencer_if #(.XLEN(XLEN)) bus ();

   muldiv_sequencer #(.XLEN(XLEN)) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // ---------------- reference model ----------------
   function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb, ua, ub, q;
      logic [63:0] pu, ps;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'b0, a});
      ub = longint'({32'b0, b});
      pu = {32'b0, a} * {32'b0, b};
      case (f)
         3'd0: return pu[31:0];
         3'd1: begin ps = sa * sb; return ps[63:32]; end
         3'd2: begin ps = sa * ub; return ps[63:32]; end
         3'd3: return pu[63:32];
         3'd4: begin if (b == 0) return 32'hFFFF_FFFF; q = sa / sb; return q[31:0]; end
         3'd5: begin if (b == 0) return 32'hFFFF_FFFF; q = ua / ub; return q[31:0]; end
         3'd6: begin if (b == 0) return a; q = sa % sb; return q[31:0]; end
         default: begin if (b == 0) return a; q = ua % ub; return q[31:0]; end
      endcase
   endfunction

   function automatic bit model_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      return f[2] && (b == 0 || (!f[0] && a == INT_MIN && b == 32'hFFFF_FFFF));
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFF_FFFF;
         3: return INT_MIN;
         4: return 32'(int'($urandom_range(0, 20)));
         default: return $urandom;
      endcase
   endfunction

   // ---------------- driver (observation only, no checking) ----------------
   task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output int busy_n, output bit timeout);
      @(negedge clk);
      bus.start_i  = 1'b1;
      bus.funct3_i = f;
      bus.rs1_i    = a;
      bus.rs2_i    = b;
      lat     = 0;
      busy_n  = 0;
      timeout = 1'b1;
      res     = '0;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clk); #1;
         bus.start_i = 1'b0;
         if (bus.busy_o) busy_n++;
         if (bus.done_o) begin
            lat     = i;
            res     = bus.result_o;
            timeout = 1'b0;
            break;
         end
      end
   endtask

   task automatic apply_reset();
      rst_n        = 1'b0;
      bus.start_i  = 1'b0;
      bus.flush_i  = 1'b0;
      bus.funct3_i = '0;
      bus.rs1_i    = '0;
      bus.rs2_i    = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      #1;
      checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy_o); end
      checks++; if (bus.done_o !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done_o); end
      checks++; if (bus.result_o !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=0", bus.result_o); end
   endtask

   task automatic test_directed();
      logic [2:0]  f   [8] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7};
      logic [31:0] a   [8] = '{32'd7, 32'hFFFF_FFFF, INT_MIN, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
      logic [31:0] b   [8] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, INT_MIN, 32'd2, 32'd2, 32'd2, 32'd7, 32'd7};
      logic [31:0] exp [8] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'h4000_0000, 32'hFFFF_FFFF,
                               32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
      logic [31:0] res;
      int lat, busy_n;
      bit to;
      for (int i = 0; i < 8; i++) begin
         run_op(f[i], a[i], b[i], res, lat, busy_n, to);
         checks++; if (to || res !== exp[i]) begin failures++; $display("FAIL directed_%0d_result got=%h exp=%h timeout=%0b", i, res, exp[i], to); end
         checks++; if (lat !== 34) begin failures++; $display("FAIL directed_%0d_latency got=%0d exp=34", i, lat); end
         checks++; if (busy_n !== 33) begin failures++; $display("FAIL directed_%0d_busy_cycles got=%0d exp=33", i, busy_n); end
         if (i == 0) begin
            @(posedge clk); #1;
            checks++; if (bus.done_o !== 1'b0) begin failures++; $display("FAIL done_pulse_width got=%b exp=0", bus.done_o); end
            checks++; if (bus.result_o !== exp[0]) begin failures++; $display("FAIL result_hold got=%h exp=%h", bus.result_o, exp[0]); end
         end
      end
   endtask

   task automatic test_special();
      logic [2:0]  f   [4] = '{3'd5, 3'd6, 3'd4, 3'd6};
      logic [31:0] a   [4] = '{32'd5, 32'd5, INT_MIN, INT_MIN};
      logic [31:0] b   [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [31:0] exp [4] = '{32'hFFFF_FFFF, 32'd5, INT_MIN, 32'd0};
      logic [31:0] res;
      int lat, busy_n;
      bit to;
      for (int i = 0; i < 4; i++) begin
         run_op(f[i], a[i], b[i], res, lat, busy_n, to);
         checks++; if (to || res !== exp[i]) begin failures++; $display("FAIL special_%0d_result got=%h exp=%h", i, res, exp[i]); end
         checks++; if (lat !== 1) begin failures++; $display("FAIL special_%0d_latency got=%0d exp=1", i, lat); end
         checks++; if (busy_n !== 0) begin failures++; $display("FAIL special_%0d_busy_cycles got=%0d exp=0", i, busy_n); end
      end
   endtask

   task automatic test_random();
      logic [2:0]  f;
      logic [31:0] a, b, res, exp;
      int lat, busy_n, exp_lat;
      bit to;
      for (int i = 0; i < 60; i++) begin
         f = 3'($urandom_range(0, 7));
         a = pick_operand();
         b = pick_operand();
         exp     = model(f, a, b);
         exp_lat = model_special(f, a, b) ? 1 : 34;
         run_op(f, a, b, res, lat, busy_n, to);
         checks++;
         if (to || res !== exp || lat !== exp_lat) begin
            failures++;
            $display("FAIL random_%0d f=%0d a=%h b=%h got=%h lat=%0d exp=%h lat=%0d", i, f, a, b, res, lat, exp, exp_lat);
         end
      end
   endtask

   task automatic test_flush();
      logic [31:0] res, prev;
      int lat, busy_n, dones;
      bit to;
      run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, prev, lat, busy_n, to);
      // Start a MUL, flush at CALC cycle 10.
      @(negedge clk);
      bus.start_i  = 1'b1;
      bus.funct3_i = 3'd0;
      bus.rs1_i    = 32'd9;
      bus.rs2_i    = 32'd11;
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk); #1;
         bus.start_i = 1'b0;
      end
      bus.flush_i = 1'b1;
      @(posedge clk); #1;
      bus.flush_i = 1'b0;
      checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL flush_busy got=%b exp=0", bus.busy_o); end
      dones = 0;
      repeat (40) begin @(posedge clk); #1; if (bus.done_o) dones++; end
      checks++; if (dones !== 0) begin failures++; $display("FAIL flush_no_done got=%0d exp=0", dones); end
      checks++; if (bus.result_o !== prev) begin failures++; $display("FAIL flush_result_hold got=%h exp=%h", bus.result_o, prev); end
      // Flush in IDLE suppresses a same-cycle start.
      @(negedge clk);
      bus.start_i = 1'b1;
      bus.flush_i = 1'b1;
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      bus.flush_i = 1'b0;
      dones = 0;
      checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL idle_flush_busy got=%b exp=0", bus.busy_o); end
      repeat (40) begin @(posedge clk); #1; if (bus.done_o) dones++; end
      checks++; if (dones !== 0) begin failures++; $display("FAIL idle_flush_no_done got=%0d exp=0", dones); end
      // Normal op after the flush.
      run_op(3'd0, 32'd9, 32'd11, res, lat, busy_n, to);
      checks++; if (to || res !== 32'd99 || lat !== 34) begin failures++; $display("FAIL after_flush got=%h lat=%0d exp=%h lat=34", res, lat, 32'd99); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] res;
      int lat, busy_n, t1, t2;
      bit to, seen;
      run_op(3'd0, 32'd3, 32'd4, res, lat, busy_n, to);
      t1 = cyc;
      checks++; if (to || res !== 32'd12) begin failures++; $display("FAIL b2b_first got=%h exp=%h", res, 32'd12); end
      // Still in the DONE cycle: present the next start now.
      bus.start_i = 1'b1;
      bus.rs1_i   = 32'd5;
      bus.rs2_i   = 32'd6;
      seen = 1'b0;
      t2   = 0;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clk); #1;
         bus.start_i = 1'b0;
         if (bus.done_o) begin seen = 1'b1; t2 = cyc; res = bus.result_o; break; end
      end
      checks++; if (!seen || res !== 32'd30) begin failures++; $display("FAIL b2b_second got=%h exp=%h seen=%0b", res, 32'd30, seen); end
      checks++; if (t2 - t1 !== 34) begin failures++; $display("FAIL b2b_spacing got=%0d exp=34", t2 - t1); end
   endtask

   task automatic test_reset_mid();
      int dones;
      @(negedge clk);
      bus.start_i  = 1'b1;
      bus.funct3_i = 3'd4;
      bus.rs1_i    = 32'd1000;
      bus.rs2_i    = 32'd7;
      repeat (5) begin @(posedge clk); #1; bus.start_i = 1'b0; end
      rst_n = 1'b0;
      #1;
      checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", bus.busy_o); end
      checks++; if (bus.done_o !== 1'b0) begin failures++; $display("FAIL midrst_done got=%b exp=0", bus.done_o); end
      checks++; if (bus.result_o !== 32'h0) begin failures++; $display("FAIL midrst_result got=%h exp=0", bus.result_o); end
      @(negedge clk);
      rst_n = 1'b1;
      dones = 0;
      repeat (40) begin @(posedge clk); #1; if (bus.done_o) dones++; end
      checks++; if (dones !== 0) begin failures++; $display("FAIL midrst_no_done got=%0d exp=0", dones); end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      cyc      = 0;
      apply_reset();
      test_reset();
      test_directed();
      test_special();
      test_random();
      test_flush();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle RV32M multiply/divide unit that sequences a shared iterative shift-add/restoring-subtract datapath for all eight M-extension operations. It sits beside the single-cycle ALU in EX. When `funct7[0]` marks an M instruction, the pipeline asserts `start_i` and stalls on `busy_o` until the one-cycle `done_o` result pulse. Covers MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU in addition to MUL.

## Interface
- `XLEN`, default 32: operand/result width.
- `clk_i` input 1: single clock; all state changes on the rising edge.
- `rst_n_i` input 1: asynchronous, active-low reset.
- `start_i` input 1: request a new operation; sampled only in IDLE or DONE.
- `funct3_i` input 3: operation select. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1_i` input XLEN: multiplicand/dividend.
- `rs2_i` input XLEN: multiplier/divisor.
- `flush_i` input 1: abort the in-flight operation (branch mispredict/trap).
- `busy_o` output 1: operation in progress; the pipeline holds EX while it is high.
- `done_o` output 1: one-cycle pulse; `result_o` is valid this cycle.
- `result_o` output XLEN: result; holds its value until the next `done_o`.

## Operation
- States:
  - IDLE: reset state.
  - CALC: XLEN iterations.
  - FIX: sign correction and result selection.
  - DONE: pulses `done_o`.
- Transitions:
  - IDLE/DONE with `start_i=1` -> CALC. Latches funct3, operand signs, and operand magnitudes (two's-complement absolute value per signedness), then clears the iteration counter.
  - IDLE/DONE without `start_i` -> IDLE.
  - CALC, counter == XLEN-1 -> FIX; otherwise the counter increments.
  - FIX -> DONE.
- Signedness:
  - MULH and DIV/REM treat both operands as signed.
  - MULHSU treats rs1 as signed and rs2 as unsigned.
  - MUL, MULHU, DIVU and REMU treat both operands as unsigned. MUL's low word is sign-independent.
- Multiply: 2·XLEN-bit accumulator, one shift-add per CALC cycle on magnitudes. In FIX, negate the full 2·XLEN product if signs differ (signed ops only). MUL returns bits [XLEN-1:0]; MULH* return [2·XLEN-1:XLEN].
- Divide: restoring division, one trial subtract per cycle, quotient bit shifted in.
  - FIX negates the quotient if operand signs differ (DIV).
  - FIX gives the remainder the sign of the dividend (REM).
- Special cases, decided at start with no CALC and no FIX (start -> DONE directly):
  - Divisor 0: quotient = all ones; remainder = rs1.
  - Signed overflow (rs1 = 0x80000000, rs2 = -1): DIV = 0x80000000; REM = 0.
- `start_i` while in CALC/FIX is ignored.
- `flush_i` in CALC/FIX: next state IDLE, `busy_o` drops next cycle, no `done_o`, `result_o` unchanged. `flush_i` in IDLE/DONE has no effect except suppressing the start of that same cycle.
- Back-to-back: `start_i` during DONE is accepted. `done_o` for the old op and entry to CALC for the new op coincide.

## Timing
- Reset (asynchronous): state IDLE, `busy_o=0`, `done_o=0`, `result_o=0`, counter 0, operand registers 0.
- `busy_o` is registered: high from the cycle after the accepting edge through the FIX cycle. It is low in IDLE and DONE.
- Normal latency: start sampled at edge 0; CALC for edges 1..XLEN; FIX at XLEN+1; `done_o` high during the cycle after edge XLEN+1. That is XLEN+2 cycles from start to the done cycle (34 for XLEN=32).
- Special-case latency: `done_o` high the cycle after the accepting edge; `busy_o` stays 0.
- `result_o` and `done_o` are registered; no combinational path from inputs to outputs.
- Reset asserted mid-operation: immediate return to reset values; no `done_o` after release.

## Test plan
- MUL 7 × 0xFFFFFFFD -> `done_o` 34 cycles after start; `result_o` = 0xFFFFFFEB; `busy_o` high for exactly 33 cycles.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE. MULH 0x80000000 × 0x80000000 -> 0x40000000. MULHSU 0xFFFFFFFF × 2 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100 / 7 -> 14. REMU 100 / 7 -> 2.
- DIVU 5 / 0 -> 0xFFFFFFFF and REM 5 / 0 -> 5, each with `done_o` the cycle after start and `busy_o` never high. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
- `flush_i` at CALC cycle 10 -> `busy_o` 0 next cycle, no `done_o`, `result_o` keeps its previous value. A new start afterwards completes normally.
- Back-to-back MUL 3×4 then MUL 5×6, with start held during DONE -> two `done_o` pulses 34 cycles apart; results 12, then 30. Mid-CALC `rst_n_i` low -> all outputs 0 immediately.
